// File: rtl/counter_8bit_ctrl.sv
// rtl/counter_8bit_ctrl.sv - Avalon-MM controller sequencing the 8-bit system counter
// Start/stop, prescaled up/down stepping, terminal-count detect, one-shot/reload, TC irq.
module counter_8bit_ctrl #(
  parameter int COUNT_WIDTH    = 8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chipselect,
  input  logic [2:0]             address,
  input  logic                   write,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic                   irq,
  output logic [COUNT_WIDTH-1:0] count_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [COUNT_WIDTH-1:0]    r_count;
  logic [COUNT_WIDTH-1:0]    r_limit;
  logic [PRESCALE_WIDTH-1:0] r_presc;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_cont;
  logic                      r_irq_en;
  logic                      r_dir;
  logic                      r_tc;
  logic [31:0]               r_readdata;

  logic                      w_wr;
  logic                      w_start;
  logic                      w_stop;
  logic                      w_tick;
  logic                      w_at_term;
  logic [COUNT_WIDTH-1:0]    w_term;
  logic [COUNT_WIDTH-1:0]    w_reload;

  assign w_wr      = chipselect & write;
  assign w_start   = w_wr && (address == 3'd0) && writedata[0];
  assign w_stop    = w_wr && (address == 3'd0) && writedata[1];
  // A START/STOP write pre-empts any tick landing in the same cycle.
  assign w_tick    = (r_state == S_RUN) && (r_presc == r_prescale) && !w_start && !w_stop;
  assign w_term    = r_dir ? '0 : r_limit;
  assign w_at_term = (r_count == w_term);
  assign w_reload  = r_dir ? r_limit : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_limit    <= '0;
      r_presc    <= '0;
      r_prescale <= '0;
      r_cont     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_dir      <= 1'b0;
      r_tc       <= 1'b0;
      r_readdata <= '0;
    end else begin
      if (w_wr) begin
        case (address)
          3'd0: begin
            r_cont   <= writedata[2];
            r_irq_en <= writedata[3];
            r_dir    <= writedata[4];
          end
          3'd1: r_prescale <= writedata[PRESCALE_WIDTH-1:0];
          3'd2: r_limit    <= writedata[COUNT_WIDTH-1:0];
          3'd4: if (r_state != S_RUN) r_count <= writedata[COUNT_WIDTH-1:0];
          default: ;
        endcase
      end

      if (w_stop) begin
        r_state <= S_IDLE;
      end else if (w_start) begin
        r_state <= S_RUN;
        r_count <= writedata[4] ? r_limit : '0;
        r_presc <= '0;
      end else if (r_state == S_RUN) begin
        if (w_tick) begin
          r_presc <= '0;
          if (w_at_term) begin
            if (r_cont) r_count <= w_reload;
            else        r_state <= S_DONE;
          end else begin
            r_count <= r_dir ? r_count - 1'b1 : r_count + 1'b1;
          end
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end

      if (w_tick && w_at_term)
        r_tc <= 1'b1;
      else if (w_wr && (address == 3'd3) && writedata[0])
        r_tc <= 1'b0;

      if (chipselect) begin
        case (address)
          3'd0:    r_readdata <= {22'b0, r_state, 3'b0, r_dir, r_irq_en, r_cont, 2'b0};
          3'd1:    r_readdata <= {{(32-PRESCALE_WIDTH){1'b0}}, r_prescale};
          3'd2:    r_readdata <= {{(32-COUNT_WIDTH){1'b0}}, r_limit};
          3'd3:    r_readdata <= {30'b0, (r_state == S_RUN), r_tc};
          3'd4:    r_readdata <= {{(32-COUNT_WIDTH){1'b0}}, r_count};
          default: r_readdata <= '0;
        endcase
      end else begin
        r_readdata <= '0;
      end
    end
  end

  assign readdata  = r_readdata;
  assign irq       = r_tc & r_irq_en;
  assign count_out = r_count;

endmodule

// File: tb/tb_counter_8bit_ctrl.sv
// tb/tb_counter_8bit_ctrl.sv - directed-vector bench for counter_8bit_ctrl
module tb_counter_8bit_ctrl;

  logic        clk;
  logic        reset;
  logic        cs;
  logic [2:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  count_out;

  int n_vec;
  int n_err;

  counter_8bit_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (cs),
    .address    (addr),
    .write      (we),
    .writedata  (wdata),
    .readdata   (readdata),
    .irq        (irq),
    .count_out  (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = readdata;
    cs = 1'b0;
  endtask

  logic [31:0] d;
  int          cyc;

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count_out), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_rdata", readdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // reset mid-run
    wr(2, 10); wr(1, 0); wr(0, 32'h09);
    repeat (5) @(negedge clk);
    check("t1_count5", 32'(count_out), 5);
    cs = 1'b1; addr = 3'd4;
    @(negedge clk);
    check("t1_rd_count", readdata, 5);
    #1 reset = 1'b1;
    #1;
    check("t1_rst_count", 32'(count_out), 0);
    check("t1_rst_irq", 32'(irq), 0);
    check("t1_rst_rdata", readdata, 0);
    @(negedge clk);
    reset = 1'b0; cs = 1'b0;
    rd(0, d); check("t1_ctrl_idle", d, 0);
    rd(2, d); check("t1_limit_clr", d, 0);

    // up one-shot
    wr(2, 3); wr(1, 0); wr(0, 32'h01);
    check("t2_c0", 32'(count_out), 0);
    for (int v = 1; v <= 3; v++) begin
      @(negedge clk);
      check("t2_step", 32'(count_out), v);
    end
    @(negedge clk);
    rd(3, d); check("t2_status", d, 1);
    rd(0, d); check("t2_done", d, 32'h200);
    check("t2_hold", 32'(count_out), 3);
    check("t2_noirq", 32'(irq), 0);

    // prescaled auto-reload with irq
    wr(3, 1); wr(2, 2); wr(1, 2); wr(0, 32'h0D);
    check("t3_c0", 32'(count_out), 0);
    repeat (3) @(negedge clk);
    check("t3_c1", 32'(count_out), 1);
    repeat (3) @(negedge clk);
    check("t3_c2", 32'(count_out), 2);
    repeat (2) @(negedge clk);
    check("t3_irq_pre", 32'(irq), 0);
    @(negedge clk);
    check("t3_reload", 32'(count_out), 0);
    check("t3_irq", 32'(irq), 1);
    wr(3, 1);
    check("t3_w1c", 32'(irq), 0);
    cyc = 0;
    while (!irq && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_irq_again", cyc, 8);
    wr(0, 32'h02); wr(3, 1);

    // down one-shot, COUNT writes
    wr(2, 4); wr(1, 0); wr(0, 32'h11);
    check("t4_c4", 32'(count_out), 4);
    for (int v = 3; v >= 0; v--) begin
      @(negedge clk);
      check("t4_step", 32'(count_out), v);
    end
    @(negedge clk);
    rd(3, d); check("t4_status", d, 1);
    rd(0, d); check("t4_done", d, 32'h210);
    wr(4, 7);
    rd(4, d); check("t4_cnt_wr", d, 7);
    wr(0, 32'h11);
    wr(4, 32'h55);
    check("t4_cnt_wr_run", 32'(count_out), 3);
    wr(0, 32'h02);
    check("t4_stop_hold", 32'(count_out), 3);
    wr(3, 1);

    // START+STOP together, TC set vs W1C
    wr(2, 10); wr(0, 32'h01);
    @(negedge clk); @(negedge clk);
    wr(0, 32'h03);
    check("t5_held", 32'(count_out), 2);
    rd(0, d); check("t5_idle", d, 0);
    check("t5_held2", 32'(count_out), 2);
    wr(2, 0); wr(0, 32'h05);
    @(negedge clk);
    wr(3, 1);
    rd(3, d); check("t5_set_wins", d, 3);
    wr(0, 32'h02); wr(3, 1);
    rd(3, d); check("t5_cleared", d, 0);

    // unused addresses and read latency
    wr(1, 32'h1234);
    wr(7, 32'hFF);
    rd(6, d); check("t6_addr6", d, 0);
    rd(2, d); check("t6_limit_kept", d, 0);
    @(negedge clk);
    cs = 1'b1; addr = 3'd1;
    #1 check("t6_lat0", readdata, 0);
    @(negedge clk);
    check("t6_presc", readdata, 32'h1234);
    cs = 1'b0;
    @(negedge clk);
    check("t6_cs_low", readdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
